seq_mult_param: RTL and testbench

Parametrised sequential shift-add multiplier, successor to the fixed 8-bit signed multiplier. It computes the full 2·WIDTH-bit product of two WIDTH-bit operands at one multiplier bit per clock, in either two's-complement or unsigned mode, selected per operation. It adds a synchronous reset, a one-cycle completion pulse and defined abort/restart behaviour. It sits beside the datapath as a low-area alternative to a combinational array multiplier.

---
 rtl/seq_mult_param.sv | 55 +++++
 tb/tb_seq_mult_param.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/seq_mult_param.sv
// seq_mult_param: shift-add multiplier, one multiplier bit per clock,
// signed (two's complement) or unsigned mode selected per operation.
module seq_mult_param #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic [2*WIDTH-1:0]   Product,
    output logic                 ready,
    output logic                 done
);
    localparam int CNT_W = $clog2(WIDTH+1);
    logic [WIDTH:0]   m;
    logic [WIDTH:0]   m_sel;
    logic [WIDTH:0]   sum;
    logic [CNT_W-1:0] cnt;
    logic             mode;
    logic             last;
    logic             ext_p;
    always_comb begin
        last  = cnt == CNT_W'(WIDTH-1);
        // the multiplier MSB carries weight -2^(W-1) in signed mode
        m_sel = (last && mode) ? -m : m;
        ext_p = mode & Product[2*WIDTH-1];
        sum   = {ext_p, Product[2*WIDTH-1:WIDTH]} + m_sel;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            Product <= '0;
            m       <= '0;
            cnt     <= '0;
            mode    <= 1'b0;
            ready   <= 1'b1;
            done    <= 1'b0;
        end else if (start) begin
            Product <= {{WIDTH{1'b0}}, B};
            m       <= {signed_mode & A[WIDTH-1], A};
            cnt     <= '0;
            mode    <= signed_mode;
            ready   <= 1'b0;
            done    <= 1'b0;
        end else if (!ready) begin
            cnt     <= cnt + CNT_W'(1);
            Product <= Product[0] ? {sum, Product[WIDTH-1:1]} : {ext_p, Product[2*WIDTH-1:1]};
            ready   <= last;
            done    <= last;
        end else begin
            done    <= 1'b0;
        end
    end
endmodule

// File: tb/tb_seq_mult_param.sv
// tb_seq_mult_param: checks WIDTH=8, 16 and 3 instances against an
// arithmetic reference multiplier, plus abort, reset and back-to-back timing.
module tb_seq_mult_param;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  start_v = '0;
    logic        sm = 1'b0;
    logic [31:0] a_in = '0;
    logic [31:0] b_in = '0;
    logic [15:0] p8;
    logic [31:0] p16;
    logic [5:0]  p3;
    logic [2:0]  rdy;
    logic [2:0]  dn;
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    seq_mult_param #(.WIDTH(8)) u8 (.clk(clk), .rst_n(rst_n), .start(start_v[0]), .signed_mode(sm),
        .A(a_in[7:0]), .B(b_in[7:0]), .Product(p8), .ready(rdy[0]), .done(dn[0]));
    seq_mult_param #(.WIDTH(16)) u16 (.clk(clk), .rst_n(rst_n), .start(start_v[1]), .signed_mode(sm),
        .A(a_in[15:0]), .B(b_in[15:0]), .Product(p16), .ready(rdy[1]), .done(dn[1]));
    seq_mult_param #(.WIDTH(3)) u3 (.clk(clk), .rst_n(rst_n), .start(start_v[2]), .signed_mode(sm),
        .A(a_in[2:0]), .B(b_in[2:0]), .Product(p3), .ready(rdy[2]), .done(dn[2]));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int w_of(input int sel);
        return sel == 0 ? 8 : sel == 1 ? 16 : 3;
    endfunction

    function automatic logic [63:0] prod_of(input int sel);
        return sel == 0 ? 64'(p8) : sel == 1 ? 64'(p16) : 64'(p3);
    endfunction

    function automatic logic [63:0] model(input int w, input logic [31:0] a, input logic [31:0] b, input bit s);
        longint mask = (longint'(1) << w) - 1;
        longint av = longint'(a) & mask;
        longint bv = longint'(b) & mask;
        if (s && av[w-1]) av -= longint'(1) << w;
        if (s && bv[w-1]) bv -= longint'(1) << w;
        return 64'((av * bv) & ((longint'(1) << (2*w)) - 1));
    endfunction

    task automatic start_op(input int sel, input logic [31:0] a, input logic [31:0] b, input bit s);
        a_in = a;
        b_in = b;
        sm = s;
        start_v[sel] = 1'b1;
        @(posedge clk);
        #1;
        start_v[sel] = 1'b0;
        a_in = $urandom;
        b_in = $urandom;
        sm = 1'($urandom);
    endtask

    task automatic wait_check(input int sel, input string tag, input logic [31:0] a, input logic [31:0] b,
                              input bit s, input bit tail);
        int n = 0;
        int busy_bad = 0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (dn[sel]) begin
                n = i;
                break;
            end
            if (rdy[sel]) busy_bad++;
        end
        check({tag, " latency"}, 64'(n), 64'(w_of(sel)));
        check({tag, " product"}, prod_of(sel), model(w_of(sel), a, b, s));
        check({tag, " ready"}, 64'(rdy[sel]), 64'(1));
        if (busy_bad != 0) check({tag, " busy"}, 64'(busy_bad), 64'(0));
        if (tail) begin
            @(posedge clk);
            #1;
            check({tag, " done width"}, 64'(dn[sel]), 64'(0));
            check({tag, " hold"}, prod_of(sel), model(w_of(sel), a, b, s));
        end
    endtask

    task automatic run_op(input int sel, input string tag, input logic [31:0] a, input logic [31:0] b, input bit s);
        start_op(sel, a, b, s);
        wait_check(sel, tag, a, b, s, 1'b1);
    endtask

    initial begin
        logic [31:0] corner [5];
        logic [31:0] mask;
        repeat (2) @(posedge clk);
        #1;
        check("reset product", prod_of(0), 64'(0));
        check("reset ready", 64'(rdy), 64'(3'b111));
        check("reset done", 64'(dn), 64'(0));
        rst_n = 1'b1;

        run_op(0, "s -128*-128", 32'h80, 32'h80, 1'b1);
        run_op(0, "s 7*-3", 32'h07, 32'hFD, 1'b1);
        run_op(0, "s -1*1", 32'hFF, 32'h01, 1'b1);
        run_op(0, "u ff*ff", 32'hFF, 32'hFF, 1'b0);
        run_op(0, "u 80*02", 32'h80, 32'h02, 1'b0);
        check("u 80*02 literal", prod_of(0), 64'h0100);

        start_op(0, 32'd5, 32'd5, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        start_op(0, 32'd3, 32'd4, 1'b0);
        wait_check(0, "abort", 32'd3, 32'd4, 1'b0, 1'b1);

        start_op(0, 32'd5, 32'd5, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("midop reset product", prod_of(0), 64'(0));
        check("midop reset ready", 64'(rdy[0]), 64'(1));
        check("midop reset done", 64'(dn[0]), 64'(0));

        start_op(0, 32'h12, 32'h34, 1'b0);
        wait_check(0, "b2b first", 32'h12, 32'h34, 1'b0, 1'b0);
        start_op(0, 32'hF3, 32'h25, 1'b1);
        check("b2b done width", 64'(dn[0]), 64'(0));
        check("b2b ready low", 64'(rdy[0]), 64'(0));
        wait_check(0, "b2b second", 32'hF3, 32'h25, 1'b1, 1'b1);

        start_v[0] = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (rdy[0] || dn[0]) check("held start", 64'({rdy[0], dn[0]}), 64'(0));
        end
        check("held start ready", 64'(rdy[0]), 64'(0));
        start_v[0] = 1'b0;
        wait_check(0, "held start release", a_in, b_in, sm, 1'b1);

        for (int sel = 0; sel < 3; sel++) begin
            mask = 32'((longint'(1) << w_of(sel)) - 1);
            corner = '{32'd0, 32'd1, mask, 32'd1 << (w_of(sel) - 1), mask >> 1};
            for (int s = 0; s < 2; s++)
                for (int i = 0; i < 5; i++)
                    for (int j = 0; j < 5; j++)
                        run_op(sel, $sformatf("corner w%0d s%0d %0d,%0d", w_of(sel), s, i, j),
                               corner[i], corner[j], 1'(s));
        end

        for (int sel = 1; sel < 3; sel++)
            for (int s = 0; s < 2; s++)
                for (int k = 0; k < 1000; k++) begin
                    logic [31:0] ra = $urandom;
                    logic [31:0] rb = $urandom;
                    start_op(sel, ra, rb, 1'(s));
                    wait_check(sel, $sformatf("rand w%0d s%0d #%0d", w_of(sel), s, k), ra, rb, 1'(s), 1'b0);
                end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
